// File: rtl/dm_pipelined.sv
// Pipelined data-memory unit for the load/store path.
// Accepts one load or store per cycle, computes base+imm, performs byte/half/word
// accesses with sign/zero extension, flags range and alignment faults, and returns
// a tagged response READ_LATENCY cycles later with valid/ready back-pressure.
module dm_pipelined #(
  parameter int MEMORY_BITS   = 12,
  parameter int ROB_SIZE_bits = 4,
  parameter int READ_LATENCY  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [1:0]               req_size,
  input  logic                     req_signed,
  input  logic [ROB_SIZE_bits:0]   req_ROBEN,
  input  logic [31:0]              req_base,
  input  logic [31:0]              req_imm,
  input  logic [31:0]              req_data,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ROB_SIZE_bits:0]   resp_ROBEN,
  output logic [31:0]              resp_result,
  output logic                     resp_write,
  output logic                     resp_invalid_address,
  output logic                     resp_misaligned
);

  localparam int DEPTH  = 1 << MEMORY_BITS;
  localparam int TAG_W  = ROB_SIZE_bits + 1;
  // Registered stages after stage 0; sized to at least 1 so the arrays stay legal.
  localparam int PIPE_N = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;

  // ------------------------------------------------------------------
  // Request decode
  // ------------------------------------------------------------------
  logic [31:0]            ea;
  logic [MEMORY_BITS-1:0] word_idx;
  logic [1:0]             ea_lane;
  logic                   invalid_addr;
  logic                   misaligned;
  logic                   fault;
  logic                   stall;
  logic                   accept;
  logic [3:0]             lane_en;
  logic [31:0]            wdata_lanes;
  logic [31:0]            rdata_word;

  assign ea           = req_base + req_imm;
  assign word_idx     = ea[MEMORY_BITS+1:2];
  assign ea_lane      = ea[1:0];
  assign invalid_addr = |ea[31:MEMORY_BITS+2];
  assign misaligned   = ((req_size == 2'b01) && ea[0]) ||
                        ((req_size == 2'b10) && (ea[1:0] != 2'b00)) ||
                        (req_size == 2'b11);
  assign fault        = invalid_addr || misaligned;

  // The whole pipeline freezes while the head response is refused.
  assign stall     = resp_valid && !resp_ready;
  assign req_ready = !stall;
  // Requests presented during reset are never taken.
  assign accept    = req_valid && req_ready && !rst;

  // Byte-lane enables for sub-word stores
  always_comb begin
    lane_en = 4'b0000;
    case (req_size)
      2'b00:   lane_en[ea_lane] = 1'b1;
      2'b01:   lane_en = ea_lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

  // Replicate store data so each lane finds its byte at its own position.
  always_comb begin
    case (req_size)
      2'b00:   wdata_lanes = {4{req_data[7:0]}};
      2'b01:   wdata_lanes = {2{req_data[15:0]}};
      default: wdata_lanes = req_data;
    endcase
  end

  // ------------------------------------------------------------------
  // Memory: one byte-wide array per lane, registered read on accept
  // ------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH];
      logic [7:0] rd_byte_reg;
      logic       wr_en;
      logic       rd_en;

      assign wr_en = accept && req_write && !fault && lane_en[gi];
      assign rd_en = accept && !req_write;

      // Lane write and read share the port; only one request per cycle.
      always_ff @(posedge clk) begin
        if (wr_en) begin
          mem_lane[word_idx] <= wdata_lanes[gi*8 +: 8];
        end
        if (rd_en) begin
          rd_byte_reg <= mem_lane[word_idx];
        end
      end

      assign rdata_word[gi*8 +: 8] = rd_byte_reg;
    end
  endgenerate

  // ------------------------------------------------------------------
  // Stage 0: request metadata captured alongside the memory read
  // ------------------------------------------------------------------
  logic             s0_valid_reg;
  logic [TAG_W-1:0] s0_roben_reg;
  logic             s0_write_reg;
  logic             s0_inv_reg;
  logic             s0_mis_reg;
  logic [1:0]       s0_size_reg;
  logic [1:0]       s0_lane_reg;
  logic             s0_signed_reg;
  logic [31:0]      s0_result;

  // Capture the accepted request; a cycle without accept loads a clean bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_reg  <= 1'b0;
      s0_roben_reg  <= '0;
      s0_write_reg  <= 1'b0;
      s0_inv_reg    <= 1'b0;
      s0_mis_reg    <= 1'b0;
      s0_size_reg   <= 2'b00;
      s0_lane_reg   <= 2'b00;
      s0_signed_reg <= 1'b0;
    end else if (!stall) begin
      s0_valid_reg  <= accept;
      s0_roben_reg  <= accept ? req_ROBEN : '0;
      s0_write_reg  <= accept && req_write;
      s0_inv_reg    <= accept && invalid_addr;
      s0_mis_reg    <= accept && misaligned;
      s0_size_reg   <= accept ? req_size : 2'b00;
      s0_lane_reg   <= accept ? ea_lane : 2'b00;
      s0_signed_reg <= accept && req_signed;
    end
  end

  // Lane select plus sign/zero extension of the raw memory word.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] ln, input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (ln)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = ln[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = {{24{sg & b[7]}}, b};
      2'b01:   r = {{16{sg & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Stores, faults and bubbles all report a zero result.
  assign s0_result = (s0_valid_reg && !s0_write_reg && !s0_inv_reg && !s0_mis_reg)
                   ? extract(rdata_word, s0_size_reg, s0_lane_reg, s0_signed_reg)
                   : 32'h0;

  // ------------------------------------------------------------------
  // Remaining response stages
  // ------------------------------------------------------------------
  logic             pipe_valid_reg  [PIPE_N];
  logic [TAG_W-1:0] pipe_roben_reg  [PIPE_N];
  logic [31:0]      pipe_result_reg [PIPE_N];
  logic             pipe_write_reg  [PIPE_N];
  logic             pipe_inv_reg    [PIPE_N];
  logic             pipe_mis_reg    [PIPE_N];

  // Uniform view of every stage: index 0 is stage 0, index k is pipe register k-1.
  logic             stage_valid  [READ_LATENCY];
  logic [TAG_W-1:0] stage_roben  [READ_LATENCY];
  logic [31:0]      stage_result [READ_LATENCY];
  logic             stage_write  [READ_LATENCY];
  logic             stage_inv    [READ_LATENCY];
  logic             stage_mis    [READ_LATENCY];

  assign stage_valid[0]  = s0_valid_reg;
  assign stage_roben[0]  = s0_roben_reg;
  assign stage_result[0] = s0_result;
  assign stage_write[0]  = s0_write_reg;
  assign stage_inv[0]    = s0_inv_reg;
  assign stage_mis[0]    = s0_mis_reg;

  generate
    for (gi = 1; gi < READ_LATENCY; gi++) begin : g_stage_view
      assign stage_valid[gi]  = pipe_valid_reg[gi-1];
      assign stage_roben[gi]  = pipe_roben_reg[gi-1];
      assign stage_result[gi] = pipe_result_reg[gi-1];
      assign stage_write[gi]  = pipe_write_reg[gi-1];
      assign stage_inv[gi]    = pipe_inv_reg[gi-1];
      assign stage_mis[gi]    = pipe_mis_reg[gi-1];
    end
  endgenerate

  // Shift every stage forward together; bubbles travel like real entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE_N; k++) begin
        pipe_valid_reg[k]  <= 1'b0;
        pipe_roben_reg[k]  <= '0;
        pipe_result_reg[k] <= 32'h0;
        pipe_write_reg[k]  <= 1'b0;
        pipe_inv_reg[k]    <= 1'b0;
        pipe_mis_reg[k]    <= 1'b0;
      end
    end else if (!stall) begin
      for (int k = 0; k < READ_LATENCY - 1; k++) begin
        pipe_valid_reg[k]  <= stage_valid[k];
        pipe_roben_reg[k]  <= stage_roben[k];
        pipe_result_reg[k] <= stage_result[k];
        pipe_write_reg[k]  <= stage_write[k];
        pipe_inv_reg[k]    <= stage_inv[k];
        pipe_mis_reg[k]    <= stage_mis[k];
      end
    end
  end

  // The last stage drives the response port.
  assign resp_valid           = stage_valid[READ_LATENCY-1];
  assign resp_ROBEN           = stage_roben[READ_LATENCY-1];
  assign resp_result          = stage_result[READ_LATENCY-1];
  assign resp_write           = stage_write[READ_LATENCY-1];
  assign resp_invalid_address = stage_inv[READ_LATENCY-1];
  assign resp_misaligned      = stage_mis[READ_LATENCY-1];

endmodule

// File: doc/dm_pipelined.md
Name: dm_pipelined

Overview:
Parametrised, pipelined data-memory unit for the SSOOO load/store path. It accepts one load or store per cycle from the load/store buffer and computes the effective address as base plus immediate. It supports byte, half and word accesses with sign or zero extension, and flags out-of-range and misaligned accesses. Each response carries its ROB tag and returns after a configurable latency, with valid/ready back-pressure toward the CDB arbiter.

Parameters:
MEMORY_BITS, 12, log2 of memory depth in 32-bit words (4096 words = 16 KiB, byte-addressed).
ROB_SIZE_bits, 4, ROB tag width is ROB_SIZE_bits+1.
READ_LATENCY, 2, cycles from accept to response; legal range 1..4.

Ports:
clk  in  1  single clock, all logic on posedge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  unit can accept this cycle.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned).
req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend.
req_ROBEN  in  ROB_SIZE_bits+1  ROB tag of the request.
req_base  in  32  base register value (ROBEN1_VAL).
req_imm  in  32  immediate offset.
req_data  in  32  store data; low byte/half used for sub-word stores.
resp_valid  out  1  response present.
resp_ready  in  1  consumer takes response.
resp_ROBEN  out  ROB_SIZE_bits+1  tag of the response.
resp_result  out  32  load data after lane select and extension; 0 for stores and faults.
resp_write  out  1  response belongs to a store.
resp_invalid_address  out  1  effective address out of range.
resp_misaligned  out  1  alignment fault.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: resp_valid=0, resp_ROBEN=0, resp_result=0, resp_write=0, resp_invalid_address=0, resp_misaligned=0. All pipeline valid bits clear. req_ready=1 in the cycle after rst deasserts.
- Reset does not clear memory. Memory is all-zero at simulation start.
- Reset mid-operation: all in-flight responses are dropped without being emitted. Stores already accepted remain written.
- Accept: a request is accepted on a posedge where req_valid && req_ready.
- Stall: stall = resp_valid && !resp_ready. req_ready = !stall (combinational). While stalled, the whole pipeline holds and the response outputs stay stable.
- Effective address: ea = req_base + req_imm, 32-bit modulo with carry discarded.
- Word index = ea[MEMORY_BITS+1:2]; byte lane = ea[1:0].
- invalid_address = (ea[31:MEMORY_BITS+2] != 0).
- misaligned = (size==01 && ea[0]) || (size==10 && ea[1:0]!=0) || size==11.
- If either fault is set: no memory write and no read data (result 0). A response is still produced with the fault flags set. invalid_address and misaligned may both be 1.
- Stores: the write is performed on the accept edge using byte-lane enables.
  - Byte: lane ea[1:0] gets req_data[7:0].
  - Half: lanes {ea[1],0} and {ea[1],1} get req_data[15:0], little-endian.
  - Word: all four lanes get req_data.
- Loads: memory is read on the accept edge. The extracted lane(s) are zero- or sign-extended per req_signed. Word loads ignore req_signed.
- Ordering: a load accepted on the edge after a store sees the store's data. Only one request is accepted per cycle, so there are no simultaneous-access hazards.
- Latency: a request accepted at edge E produces resp_valid from edge E+READ_LATENCY-1 onward, absent stalls. Each stall cycle adds one cycle.
- Throughput: with resp_ready held high, one response per cycle, emitted in accept order.
- Pipeline: READ_LATENCY stages of {valid, ROBEN, result, write, invalid, misaligned}. Stages advance only when !stall.
- Bubbles: empty stages do not compress. Bubbles propagate and emit resp_valid=0.

Test Plan:
- Word round trip, READ_LATENCY=2: store base=0x100 imm=4 data=0xDEADBEEF ROBEN=3, then load same ea signed ROBEN=5 → responses in order; load response has resp_ROBEN=5, result 0xDEADBEEF, arriving 2 cycles after its accept.
- Sub-word: load byte at ea=0x105 from the word above, signed → 0xFFFFFFBE; unsigned → 0x000000BE. Store half 0x1234 at ea=0x106, then word load → 0x1234BEEF.
- Faults: base=0x3FFC imm=4 (ea=0x4000) word load → invalid_address=1, result 0. Half load at ea=0x101 → misaligned=1. Word store to ea=0x4000 → invalid_address=1 and memory unchanged, confirmed by reading back ea=0x0.
- Back-pressure: stream 4 loads with resp_ready=0 for 3 cycles once the first response appears → req_ready=0 throughout, resp outputs stable; after release, 4 responses in order with no loss or duplication.
- Reset mid-flight: issue 2 loads, assert rst 1 cycle after the first accept → no resp_valid afterwards; a store accepted before rst is still readable after reset.
- Wrap: base=0xFFFFFFFC imm=8 (ea=0x4) word load → valid access to word 1, no fault.
